// File: rtl/morse_msg_sequencer_if.sv
// Letter-queue handshake and keyer status bundle between a producer and morse_msg_sequencer.
interface morse_msg_sequencer_if #(
  parameter int PTR_W = 2
);
  logic           push;
  logic [2:0]     letter;
  logic           abort;
  logic           out;
  logic           busy;
  logic           letter_done;
  logic           full;
  logic           empty;
  logic [PTR_W:0] count;

  modport master (
    output push, letter, abort,
    input  out, busy, letter_done, full, empty, count
  );

  modport slave (
    input  push, letter, abort,
    output out, busy, letter_done, full, empty, count
  );
endinterface

// File: rtl/morse_msg_sequencer.sv
// Queues A..H letter codes and keys them out with Morse unit timing derived from clk.
//
// state | meaning
// IDLE  | nothing in flight; pops the queue head when one is waiting
// LOAD  | latch pattern/length of the popped letter, arm first symbol
// MARK  | keyer on for a dot (1 unit) or dash (3 units)
// SPACE | 1-unit intra-letter gap
// LGAP  | 3-unit inter-letter gap
module morse_msg_sequencer #(
  parameter int TICK_DIV = 25000000,
  parameter int PTR_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  morse_msg_sequencer_if.slave  bus
);

  localparam int DEPTH = 2 ** PTR_W;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, MARK, SPACE, LGAP} state_t;

  state_t           state, state_d;
  logic [2:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, push_ok, pop;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [2:0]       cur_letter;
  logic [3:0]       pat, pat_d, rom_pat;
  logic [2:0]       len, len_d, rom_len;
  logic [1:0]       idx, idx_d, units, units_d;
  logic             done_d, letter_done;

  assign full    = (count == COUNT_FULL);
  assign empty   = (count == '0);
  assign push_ok = bus.push && !full && !bus.abort;
  assign tick    = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cur_letter <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= bus.letter;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        cur_letter <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // pattern bit i = 1 means symbol i is a dash; symbols go out from bit 0 upward
  always_comb begin
    rom_pat = 4'b0000;
    rom_len = 3'd1;
    case (cur_letter)
      3'd0: begin rom_pat = 4'b0010; rom_len = 3'd2; end
      3'd1: begin rom_pat = 4'b0001; rom_len = 3'd4; end
      3'd2: begin rom_pat = 4'b0101; rom_len = 3'd4; end
      3'd3: begin rom_pat = 4'b0001; rom_len = 3'd3; end
      3'd4: begin rom_pat = 4'b0000; rom_len = 3'd1; end
      3'd5: begin rom_pat = 4'b0100; rom_len = 3'd4; end
      3'd6: begin rom_pat = 4'b0011; rom_len = 3'd3; end
      3'd7: begin rom_pat = 4'b0000; rom_len = 3'd4; end
      default: ;
    endcase
  end

  // held at zero outside timed states so each first mark gets a full unit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      tick_cnt <= '0;
    else if (bus.abort || state == IDLE || state == LOAD || tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      units       <= '0;
      idx         <= '0;
      pat         <= '0;
      len         <= '0;
      letter_done <= 1'b0;
    end else begin
      state       <= state_d;
      units       <= units_d;
      idx         <= idx_d;
      pat         <= pat_d;
      len         <= len_d;
      letter_done <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    units_d = units;
    idx_d   = idx;
    pat_d   = pat;
    len_d   = len;
    done_d  = 1'b0;
    pop     = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = LOAD;
          end
        end
        LOAD: begin
          pat_d   = rom_pat;
          len_d   = rom_len;
          idx_d   = '0;
          units_d = rom_pat[0] ? 2'd3 : 2'd1;
          state_d = MARK;
        end
        MARK: begin
          if (tick) begin
            if (units == 2'd1) begin
              if (({1'b0, idx} + 3'd1) < len) begin
                idx_d   = idx + 2'd1;
                units_d = 2'd1;
                state_d = SPACE;
              end else begin
                units_d = 2'd3;
                done_d  = 1'b1;
                state_d = LGAP;
              end
            end else begin
              units_d = units - 2'd1;
            end
          end
        end
        SPACE: begin
          if (tick) begin
            units_d = pat[idx] ? 2'd3 : 2'd1;
            state_d = MARK;
          end
        end
        LGAP: begin
          if (tick) begin
            if (units == 2'd1) state_d = IDLE;
            else               units_d = units - 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.out         = (state == MARK);
  assign bus.busy        = (state != IDLE);
  assign bus.letter_done = letter_done;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.count       = count;

endmodule

// File: tb/tb_morse_msg_sequencer.sv
// Bench for morse_msg_sequencer: queue/timeline model checked every cycle plus directed literal checks.
module tb_morse_msg_sequencer;
  localparam int TD    = 4;
  localparam int PW    = 2;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  morse_msg_sequencer_if #(.PTR_W(PW)) bus ();
  morse_msg_sequencer #(.TICK_DIV(TD), .PTR_W(PW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // model: letters waiting, and per-cycle {out, busy, letter_done} of the letter in flight
  logic [2:0] mq[$];
  logic [2:0] tl[$];
  logic       exp_out  = 1'b0;
  logic       exp_busy = 1'b0;
  logic       exp_done = 1'b0;

  function automatic string morse_of(input logic [2:0] l);
    case (l)
      3'd0:    return ".-";
      3'd1:    return "-...";
      3'd2:    return "-.-.";
      3'd3:    return "-..";
      3'd4:    return ".";
      3'd5:    return "..-.";
      3'd6:    return "--.";
      default: return "....";
    endcase
  endfunction

  task automatic build(input logic [2:0] l);
    string s;
    byte   c;
    int    u;
    s = morse_of(l);
    tl.push_back(3'b010);
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      u = (c == "-") ? 3 : 1;
      repeat (u * TD) tl.push_back(3'b110);
      if (i != s.len() - 1) repeat (TD) tl.push_back(3'b010);
    end
    tl.push_back(3'b011);
    repeat (3 * TD - 1) tl.push_back(3'b010);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      mq.delete();
      tl.delete();
      {exp_out, exp_busy, exp_done} = 3'b000;
    end else begin
      bit         full_pre;
      logic [2:0] e;
      full_pre = (mq.size() == DEPTH);
      if (bus.abort) begin
        mq.delete();
        tl.delete();
      end else begin
        if (!exp_busy && mq.size() != 0) build(mq.pop_front());
        if (bus.push && !full_pre) mq.push_back(bus.letter);
      end
      e = (tl.size() != 0) ? tl.pop_front() : 3'b000;
      {exp_out, exp_busy, exp_done} = e;
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset && chk_en) begin
      logic [7:0] act;
      logic [7:0] req;
      act = {bus.out, bus.busy, bus.letter_done, bus.full, bus.empty, bus.count};
      req = {exp_out, exp_busy, exp_done, mq.size() == DEPTH, mq.size() == 0, 3'(mq.size())};
      checks++;
      if (act !== req) begin
        failures++;
        $display("FAIL cycle t=%0t out,busy,done,full,empty,count actual=%b required=%b", $time, act, req);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_one(input logic [2:0] l);
    @(negedge clk);
    bus.push   = 1'b1;
    bus.letter = l;
    @(negedge clk);
    bus.push   = 1'b0;
  endtask

  task automatic wait_out_high(input string name);
    int n;
    n = 0;
    while (!bus.out && n < 30) begin @(negedge clk); n++; end
    if (!bus.out) chk(name, 0, 1);
  endtask

  task automatic measure(output int busy_cyc, output int out_cyc, output int done_cnt,
                         output int first_mark);
    int n;
    bit seen_hi, first_over;
    busy_cyc = 0; out_cyc = 0; done_cnt = 0; first_mark = 0;
    seen_hi = 1'b0; first_over = 1'b0; n = 0;
    while (!bus.busy && n < 20) begin @(negedge clk); n++; end
    if (!bus.busy) begin
      chk("busy_rise", 0, 1);
      return;
    end
    n = 0;
    while (bus.busy && n < 400) begin
      busy_cyc++;
      if (bus.out) begin
        out_cyc++;
        seen_hi = 1'b1;
        if (!first_over) first_mark++;
      end else if (seen_hi) begin
        first_over = 1'b1;
      end
      if (bus.letter_done) done_cnt++;
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("busy_fall", 1, 0);
  endtask

  initial begin
    int bc, oc, dc, fm, n, ones;
    logic [2:0] seq4 [6];
    logic [2:0] pin_l [4];
    int pin_len [4];
    int pin_ones [4];

    bus.push = 1'b0; bus.letter = 3'd0; bus.abort = 1'b0;

    // pin the model's timelines against hand-counted cycle totals
    #1;
    pin_l = '{3'd4, 3'd0, 3'd1, 3'd7};
    pin_len = '{17, 33, 49, 41};
    pin_ones = '{4, 16, 24, 16};
    for (int k = 0; k < 4; k++) begin
      tl.delete();
      build(pin_l[k]);
      ones = 0;
      foreach (tl[j]) if (tl[j][2]) ones++;
      chk("model_len", tl.size(), pin_len[k]);
      chk("model_marks", ones, pin_ones[k]);
    end
    tl.delete();

    // 1: reset
    tick_n(3);
    reset = 1'b1;
    chk_en = 1'b1;
    chk("rst_out", int'(bus.out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.letter_done), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_count", int'(bus.count), 0);

    // 2: single E
    push_one(3'd4);
    measure(bc, oc, dc, fm);
    chk("E_busy_cycles", bc, 17);
    chk("E_mark_cycles", oc, 4);
    chk("E_done_pulses", dc, 1);
    chk("E_count", int'(bus.count), 0);

    // 3: single A
    tick_n(2);
    push_one(3'd0);
    measure(bc, oc, dc, fm);
    chk("A_busy_cycles", bc, 33);
    chk("A_mark_cycles", oc, 16);
    chk("A_first_mark", fm, 4);
    chk("A_done_pulses", dc, 1);

    // 4: fill queue, sixth push dropped, drain in order
    tick_n(2);
    seq4 = '{3'd2, 3'd3, 3'd6, 3'd7, 3'd1, 3'd0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        chk("fill_full", int'(bus.full), 1);
        chk("fill_count", int'(bus.count), 4);
      end
      bus.push = 1'b1;
      bus.letter = seq4[i];
    end
    @(negedge clk);
    bus.push = 1'b0;
    chk("drop_count", int'(bus.count), 4);
    dc = 0; n = 0;
    while ((bus.busy || !bus.empty) && n < 1500) begin
      if (bus.letter_done) dc++;
      @(negedge clk);
      n++;
    end
    chk("drain_done_pulses", dc, 5);
    chk("drain_idle", int'(bus.busy), 0);

    // 5: abort inside the first dash of B with two queued
    tick_n(2);
    seq4 = '{3'd1, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.push = 1'b1;
      bus.letter = seq4[i];
    end
    @(negedge clk);
    bus.push = 1'b0;
    wait_out_high("B_out_rise");
    tick_n(4);
    chk("pre_abort_count", int'(bus.count), 2);
    chk("pre_abort_out", int'(bus.out), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_out", int'(bus.out), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_count", int'(bus.count), 0);
    chk("abort_done", int'(bus.letter_done), 0);
    tick_n(5);
    push_one(3'd4);
    measure(bc, oc, dc, fm);
    chk("post_abort_first_mark", fm, 4);
    chk("post_abort_busy_cycles", bc, 17);

    // 6: async reset mid-mark of H with E queued
    tick_n(2);
    push_one(3'd7);
    wait_out_high("H_out_rise");
    push_one(3'd4);
    chk("H_queued", int'(bus.count), 1);
    chk("H_out_mid", int'(bus.out), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_out", int'(bus.out), 0);
    chk("async_busy", int'(bus.busy), 0);
    chk("async_count", int'(bus.count), 0);
    tick_n(2);
    reset = 1'b1;
    tick_n(6);
    chk("after_rst_busy", int'(bus.busy), 0);
    chk("after_rst_empty", int'(bus.empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
